// File: rtl/draw_pkg.sv
// Shared constants and FSM state type for the Bresenham line drawer.
package draw_pkg;

  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // err needs X_W+3 bits so that 2*err fits in X_W+4 with no overflow.
  localparam int DEF_ERR_W = DEF_X_W + 3;
  localparam int DEF_E2_W  = DEF_ERR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bresenham_step.sv
// Combinational single Bresenham step: next position, next error term and end-of-line flag.
module bresenham_step
  import draw_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int ERR_W = X_W + 3
) (
  input  logic [X_W-1:0]          x,
  input  logic [Y_W-1:0]          y,
  input  logic [X_W-1:0]          x1,
  input  logic [Y_W-1:0]          y1,
  input  logic signed [ERR_W-1:0] err,
  input  logic signed [ERR_W-1:0] dx,
  input  logic signed [ERR_W-1:0] dy,
  input  logic                    sx_neg,
  input  logic                    sy_neg,
  output logic [X_W-1:0]          x_next,
  output logic [Y_W-1:0]          y_next,
  output logic signed [ERR_W-1:0] err_next,
  output logic                    at_end
);

  localparam int E2_W = ERR_W + 1;

  logic signed [E2_W-1:0] e2;
  logic signed [E2_W-1:0] dx_w;
  logic signed [E2_W-1:0] dy_w;
  logic                   step_x;
  logic                   step_y;

  always_comb begin
    e2       = {err, 1'b0};
    dx_w     = E2_W'(dx);
    dy_w     = E2_W'(dy);
    at_end   = (x == x1) && (y == y1);
    step_x   = (e2 >= dy_w);
    step_y   = (e2 <= dx_w);
    x_next   = x;
    y_next   = y;
    // Both axis updates may fire together; err takes the sum of both increments.
    err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    if (step_x) x_next = sx_neg ? x - X_W'(1) : x + X_W'(1);
    if (step_y) y_next = sy_neg ? y - Y_W'(1) : y + Y_W'(1);
  end

endmodule

// File: rtl/bresenham_line_drawer.sv
// All-octant Bresenham line drawer feeding vga_adapter, one pixel per clock.
// Define BRESENHAM_CLIP_EN to suppress plot for pixels outside SCREEN_W x SCREEN_H.
module bresenham_line_drawer
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int ERR_W = X_W + 3;

`ifdef BRESENHAM_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  state_t state, state_next;

  logic [X_W-1:0]          lx0, lx1, cx, nx;
  logic [Y_W-1:0]          ly0, ly1, cy, ny;
  logic signed [ERR_W-1:0] err_q, dx_q, dy_q, nerr;
  logic signed [ERR_W-1:0] dx_init, dy_init;
  logic                    sx_neg, sy_neg, at_end, visible;

  assign state_dbg = state;

  bresenham_step #(.X_W(X_W), .Y_W(Y_W), .ERR_W(ERR_W)) u_step (
    .x(cx), .y(cy), .x1(lx1), .y1(ly1),
    .err(err_q), .dx(dx_q), .dy(dy_q),
    .sx_neg(sx_neg), .sy_neg(sy_neg),
    .x_next(nx), .y_next(ny), .err_next(nerr), .at_end(at_end)
  );

  always_comb begin
    dx_init = ERR_W'((lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1);
    dy_init = -ERR_W'((ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1);
    visible = !CLIP || ((int'(cx) < SCREEN_W) && (int'(cy) < SCREEN_H));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = DRAW;
      DRAW:    if (at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs lag the internal position by one register so the first plot lands at k+2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lx0 <= '0; ly0 <= '0; lx1 <= '0; ly1 <= '0;
      cx <= '0; cy <= '0;
      err_q <= '0; dx_q <= '0; dy_q <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0;
      x <= '0; y <= '0; colour <= '0;
      plot <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (start) begin
            lx0 <= x0; ly0 <= y0; lx1 <= x1; ly1 <= y1;
            colour <= colour_in;
          end
        end
        INIT: begin
          dx_q   <= dx_init;
          dy_q   <= dy_init;
          err_q  <= dx_init + dy_init;
          sx_neg <= !(lx0 < lx1);
          sy_neg <= !(ly0 < ly1);
          cx     <= lx0;
          cy     <= ly0;
          busy   <= 1'b1;
        end
        DRAW: begin
          x    <= cx;
          y    <= cy;
          plot <= visible;
          if (!at_end) begin
            cx    <= nx;
            cy    <= ny;
            err_q <= nerr;
          end
        end
        DONE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Randomised self-checking bench for bresenham_line_drawer against an integer line model.
module tb_bresenham_line_drawer;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [7:0] x0, x1, x;
  logic [6:0] y0, y1, y;
  logic [2:0] colour_in, colour;
  logic       plot, busy, done;
  logic [1:0] state_dbg;

  // Expected pixel stream: {visible, x, y}.
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  bresenham_line_drawer dut (
    .clock(clock), .resetn(resetn), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Walk the ideal line from endpoint to endpoint using integer error arithmetic.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int px, py, ddx, ddy, stx, sty, e, e2, vis;
    exp_q.delete();
    px = ax0; py = ay0;
    ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    stx = (ax0 < ax1) ? 1 : -1;
    sty = (ay0 < ay1) ? 1 : -1;
    e = ddx + ddy;
    forever begin
`ifdef BRESENHAM_CLIP_EN
      vis = (px < 160 && py < 120) ? 1 : 0;
`else
      vis = 1;
`endif
      exp_q.push_back({vis[0], px[7:0], py[6:0]});
      if (px == ax1 && py == ay1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; px += stx; end
      if (e2 <= ddx) begin e += ddx; py += sty; end
    end
  endtask

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int poke_at);
    int n;
    logic [15:0] e;
    build_model(ax0, ay0, ax1, ay1);
    n = exp_q.size();
    @(negedge clock);
    x0 = ax0[7:0]; y0 = ay0[6:0]; x1 = ax1[7:0]; y1 = ay1[6:0];
    colour_in = col[2:0];
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); x1 = 8'($urandom); y1 = 7'($urandom);
    colour_in = 3'($urandom);
    check("plot_in_init", int'(plot), 0);
    @(negedge clock);
    check("busy_first", int'(busy), 1);
    check("plot_before_first", int'(plot), 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == poke_at) begin
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd50; y1 = 7'd50;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      e = exp_q.pop_front();
      check("plot", int'(plot), int'(e[15]));
      if (e[15]) begin
        check("x", int'(x), int'(e[14:7]));
        check("y", int'(y), int'(e[6:0]));
        check("colour", int'(colour), col);
      end
      check("busy_draw", int'(busy), 1);
      check("done_early", int'(done), 0);
    end
    start = 1'b0;
    @(negedge clock);
    check("done_pulse", int'(done), 1);
    check("plot_after", int'(plot), 0);
    check("busy_after", int'(busy), 0);
    @(negedge clock);
    check("done_width", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("plot_idle", int'(plot), 0);
  endtask

  task automatic reset_abort();
    build_model(0, 0, 20, 0);
    @(negedge clock);
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd20; y1 = 7'd0; colour_in = 3'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) @(negedge clock);
    check("abort_pixel_x", int'(x), 3);
    check("abort_plot", int'(plot), 1);
    resetn = 1'b0;
    #1;
    check("abort_plot_clr", int'(plot), 0);
    check("abort_busy_clr", int'(busy), 0);
    check("abort_x_clr", int'(x), 0);
    check("abort_y_clr", int'(y), 0);
    check("abort_done_clr", int'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_done", int'(done), 0);
      check("abort_no_plot", int'(plot), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
    repeat (3) @(negedge clock);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    resetn = 1'b1;
    @(negedge clock);

    run_line(10, 10, 15, 10, 7, -1);
    run_line(0, 0, 3, 7, 2, -1);
    run_line(15, 10, 10, 10, 4, -1);
    run_line(5, 5, 5, 5, 1, -1);
    run_line(0, 0, 5, 0, 6, 2);
    reset_abort();
    run_line(2, 3, 9, 1, 3, -1);
    run_line(157, 5, 162, 5, 7, -1);
    run_line(0, 0, 255, 127, 5, -1);
    run_line(255, 127, 0, 0, 2, -1);
    run_line(255, 0, 0, 127, 1, -1);
    for (int t = 0; t < 24; t++) begin
      run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
